// File: rtl/sbp_lookup_scheduler.sv
// Head-of-pipeline scheduler for the lookup stage chain: arbitrates lookups against
// table updates, injects bubbles, and tracks slot occupancy to emit lookup results.
module sbp_lookup_scheduler #(
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int RESULT_BITS   = 24,
    parameter int ROOT_STAGE    = 1,
    parameter int NULL_STAGE    = 2**STAGE_ID_BITS-1,
    parameter int PIPE_LATENCY  = 16,
    parameter int MAX_LKP_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lkp_valid_i,
    output logic                     lkp_ready_o,
    input  logic [31:0]              lkp_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [31:0]              upd_prefix_i,
    input  logic [5:0]               upd_prefix_len_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0] upd_location_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    output logic                     update_o,
    output logic [31:0]              ip_addr_o,
    output logic [5:0]               bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    input  logic [31:0]              tail_ip_addr_i,
    input  logic [RESULT_BITS-1:0]   tail_result_i,
    output logic                     res_valid_o,
    output logic [31:0]              res_ip_addr_o,
    output logic [RESULT_BITS-1:0]   res_result_o,
    output logic [4:0]               inflight_o
);

    localparam int BW = $clog2(MAX_LKP_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LKP_BURST);
    localparam logic [STAGE_ID_BITS-1:0] NULL_ID = STAGE_ID_BITS'(NULL_STAGE);
    localparam logic [STAGE_ID_BITS-1:0] ROOT_ID = STAGE_ID_BITS'(ROOT_STAGE);

    logic                     upd_grant, lkp_grant;
    logic [BW-1:0]            burst_cnt_d, burst_cnt_q;
    logic                     update_d, update_q;
    logic [31:0]              ip_addr_d, ip_addr_q;
    logic [5:0]               bit_pos_d, bit_pos_q;
    logic [STAGE_ID_BITS-1:0] stage_id_d, stage_id_q;
    logic [LOCATION_BITS-1:0] location_d, location_q;
    logic [RESULT_BITS-1:0]   result_d, result_q;
    logic                     occ_head_d, occ_head_q, lkp_head_d, lkp_head_q;
    logic [PIPE_LATENCY-1:0]  occ_sh_d, occ_sh_q, lkp_sh_d, lkp_sh_q;
    logic                     res_valid_d, res_valid_q;
    logic [31:0]              res_ip_d, res_ip_q;
    logic [RESULT_BITS-1:0]   res_result_d, res_result_q;
    logic [4:0]               inflight_d, inflight_q;

    // Updates win when no lookup competes, or once the lookup burst has run its course.
    always_comb begin
        upd_grant = !rst && upd_valid_i && (!lkp_valid_i || burst_cnt_q == BURST_MAX);
        lkp_grant = !rst && lkp_valid_i && !upd_grant;
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!upd_valid_i || upd_grant)
            burst_cnt_d = '0;
        else if (lkp_grant && burst_cnt_q != BURST_MAX)
            burst_cnt_d = burst_cnt_q + 1'b1;
    end

    always_comb begin
        update_d   = 1'b0;
        ip_addr_d  = '0;
        bit_pos_d  = '0;
        stage_id_d = NULL_ID;
        location_d = '0;
        result_d   = '0;
        if (upd_grant) begin
            update_d   = 1'b1;
            ip_addr_d  = upd_prefix_i;
            bit_pos_d  = upd_prefix_len_i;
            stage_id_d = upd_stage_id_i;
            location_d = upd_location_i;
            result_d   = upd_result_i;
        end else if (lkp_grant) begin
            ip_addr_d  = lkp_ip_addr_i;
            stage_id_d = ROOT_ID;
        end
        occ_head_d = upd_grant || lkp_grant;
        lkp_head_d = lkp_grant;
    end

    // The head flop is the slot in the first stage; the last shift entry meets the tail.
    always_comb begin
        occ_sh_d = {occ_sh_q[PIPE_LATENCY-2:0], occ_head_q};
        lkp_sh_d = {lkp_sh_q[PIPE_LATENCY-2:0], lkp_head_q};
        inflight_d = '0;
        for (int i = 0; i < PIPE_LATENCY; i++)
            inflight_d = inflight_d + 5'(occ_sh_d[i]);
        res_valid_d  = occ_sh_q[PIPE_LATENCY-1] && lkp_sh_q[PIPE_LATENCY-1];
        res_ip_d     = res_valid_d ? tail_ip_addr_i : res_ip_q;
        res_result_d = res_valid_d ? tail_result_i  : res_result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q  <= '0;
            update_q     <= 1'b0;
            ip_addr_q    <= '0;
            bit_pos_q    <= '0;
            stage_id_q   <= NULL_ID;
            location_q   <= '0;
            result_q     <= '0;
            occ_head_q   <= 1'b0;
            lkp_head_q   <= 1'b0;
            occ_sh_q     <= '0;
            lkp_sh_q     <= '0;
            res_valid_q  <= 1'b0;
            res_ip_q     <= '0;
            res_result_q <= '0;
            inflight_q   <= '0;
        end else begin
            burst_cnt_q  <= burst_cnt_d;
            update_q     <= update_d;
            ip_addr_q    <= ip_addr_d;
            bit_pos_q    <= bit_pos_d;
            stage_id_q   <= stage_id_d;
            location_q   <= location_d;
            result_q     <= result_d;
            occ_head_q   <= occ_head_d;
            lkp_head_q   <= lkp_head_d;
            occ_sh_q     <= occ_sh_d;
            lkp_sh_q     <= lkp_sh_d;
            res_valid_q  <= res_valid_d;
            res_ip_q     <= res_ip_d;
            res_result_q <= res_result_d;
            inflight_q   <= inflight_d;
        end
    end

    assign lkp_ready_o   = lkp_grant;
    assign upd_ready_o   = upd_grant;
    assign update_o      = update_q;
    assign ip_addr_o     = ip_addr_q;
    assign bit_pos_o     = bit_pos_q;
    assign stage_id_o    = stage_id_q;
    assign location_o    = location_q;
    assign result_o      = result_q;
    assign res_valid_o   = res_valid_q;
    assign res_ip_addr_o = res_ip_q;
    assign res_result_o  = res_result_q;
    assign inflight_o    = inflight_q;

endmodule

// File: tb/tb_sbp_lookup_scheduler.sv
// Bench for sbp_lookup_scheduler: a delay line stands in for the stage chain and a
// scoreboard matches every accepted lookup against its result pulse.
module tb_sbp_lookup_scheduler;

    localparam int SB = 6, LB = 11, RB = 24, L = 16;

    logic          clk = 1'b0, rst;
    logic          lkp_valid_i, lkp_ready_o, upd_valid_i, upd_ready_o;
    logic [31:0]   lkp_ip_addr_i, upd_prefix_i;
    logic [5:0]    upd_prefix_len_i;
    logic [SB-1:0] upd_stage_id_i;
    logic [LB-1:0] upd_location_i;
    logic [RB-1:0] upd_result_i;
    logic          update_o;
    logic [31:0]   ip_addr_o;
    logic [5:0]    bit_pos_o;
    logic [SB-1:0] stage_id_o;
    logic [LB-1:0] location_o;
    logic [RB-1:0] result_o;
    logic [31:0]   tail_ip_addr_i;
    logic [RB-1:0] tail_result_i;
    logic          res_valid_o;
    logic [31:0]   res_ip_addr_o;
    logic [RB-1:0] res_result_o;
    logic [4:0]    inflight_o;

    sbp_lookup_scheduler dut (
        .clk(clk), .rst(rst),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip_addr_i),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_prefix_i(upd_prefix_i),
        .upd_prefix_len_i(upd_prefix_len_i), .upd_stage_id_i(upd_stage_id_i),
        .upd_location_i(upd_location_i), .upd_result_i(upd_result_i),
        .update_o(update_o), .ip_addr_o(ip_addr_o), .bit_pos_o(bit_pos_o),
        .stage_id_o(stage_id_o), .location_o(location_o), .result_o(result_o),
        .tail_ip_addr_i(tail_ip_addr_i), .tail_result_i(tail_result_i),
        .res_valid_o(res_valid_o), .res_ip_addr_o(res_ip_addr_o),
        .res_result_o(res_result_o), .inflight_o(inflight_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, res_cnt = 0;
    logic [31:0] ipq[$];
    int          cq[$];
    logic [31:0] dl[L];

    function automatic logic [RB-1:0] fres(input logic [31:0] a);
        return {a[7:0], a[31:16]} ^ 24'h5A5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in stage chain: tail shows the head slot PIPE_LATENCY cycles later.
    always @(posedge clk) begin
        for (int i = L-1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= ip_addr_o;
    end
    assign tail_ip_addr_i = dl[L-1];
    assign tail_result_i  = fres(dl[L-1]);

    always @(negedge clk) begin
        if (rst) begin
            ipq.delete();
            cq.delete();
        end else begin
            if (lkp_valid_i && lkp_ready_o) begin
                ipq.push_back(lkp_ip_addr_i);
                cq.push_back(cyc);
            end
            if (res_valid_o) begin
                res_cnt++;
                if (ipq.size() == 0) begin
                    chk("res_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [31:0] eip;
                    int          ec;
                    eip = ipq.pop_front();
                    ec  = cq.pop_front();
                    chk("res_ip", res_ip_addr_o, eip);
                    chk("res_result", res_result_o, fres(eip));
                    chk("res_latency", 64'(cyc - ec), 64'd18);
                end
            end
        end
    end

    initial begin
        int r0, n, mx;
        logic got;
        rst = 1'b1; lkp_valid_i = 1'b1; upd_valid_i = 1'b1; lkp_ip_addr_i = '0;
        upd_prefix_i = '0; upd_prefix_len_i = '0; upd_stage_id_i = '0;
        upd_location_i = '0; upd_result_i = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_lkp_ready", lkp_ready_o, 0);
        chk("rst_upd_ready", upd_ready_o, 0);
        chk("rst_stage_id", stage_id_o, 63);
        chk("rst_update", update_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        step(); rst = 1'b0; lkp_valid_i = 1'b0; upd_valid_i = 1'b0;

        // single lookup
        step(); lkp_valid_i = 1'b1; lkp_ip_addr_i = 32'h0A000001;
        @(negedge clk); chk("t1_ready", lkp_ready_o, 1);
        step(); lkp_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_stage", stage_id_o, 1);
        chk("t1_bitpos", bit_pos_o, 0);
        chk("t1_update", update_o, 0);
        chk("t1_ip", ip_addr_o, 32'h0A000001);
        r0 = res_cnt - 0;
        r0 = res_cnt;
        repeat (25) step();
        chk("t1_pulses", 64'(res_cnt - r0), 1);

        // single update
        step(); upd_valid_i = 1'b1; upd_prefix_i = 32'hC0A80000; upd_prefix_len_i = 6'd16;
        upd_stage_id_i = 6'd3; upd_location_i = 11'd5; upd_result_i = 24'h123456;
        @(negedge clk);
        chk("t2_upd_ready", upd_ready_o, 1);
        chk("t2_lkp_ready", lkp_ready_o, 0);
        step(); upd_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_update", update_o, 1);
        chk("t2_ip", ip_addr_o, 32'hC0A80000);
        chk("t2_bitpos", bit_pos_o, 16);
        chk("t2_stage", stage_id_o, 3);
        chk("t2_loc", location_o, 5);
        chk("t2_result", result_o, 24'h123456);
        r0 = res_cnt;
        repeat (20) step();
        chk("t2_no_res", 64'(res_cnt - r0), 0);
        @(negedge clk);
        chk("idle_stage", stage_id_o, 63);
        chk("idle_update", update_o, 0);

        // lookup burst versus a waiting update
        step(); lkp_valid_i = 1'b1; lkp_ip_addr_i = $urandom;
        repeat (2) begin
            upd_valid_i = 1'b1; n = 0; got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (upd_ready_o) got = 1'b1;
                else if (lkp_ready_o) n++;
                step(); lkp_ip_addr_i = $urandom;
                if (got) upd_valid_i = 1'b0;
            end
            chk("t3_burst", 64'(n), 4);
            chk("t3_upd_grant", got, 1);
            repeat (3) begin
                @(negedge clk); chk("t3_resume", lkp_ready_o, 1);
                step(); lkp_ip_addr_i = $urandom;
            end
        end
        lkp_valid_i = 1'b0;
        repeat (25) step();

        // sparse lookups with bubbles in between
        for (int i = 0; i < 6; i++) begin
            step(); lkp_valid_i = (i % 2 == 0); lkp_ip_addr_i = $urandom;
            @(negedge clk);
            if (i > 0) begin
                chk("t4_stage", stage_id_o, (i % 2 == 1) ? 1 : 63);
                chk("t4_update", update_o, 0);
            end
        end
        step(); lkp_valid_i = 1'b0;
        @(negedge clk); chk("t4_bubble", stage_id_o, 63);
        repeat (5) step();
        @(negedge clk); chk("t4_inflight", inflight_o, 3);
        repeat (25) step();
        @(negedge clk); chk("t4_drained", inflight_o, 0);

        // reset with lookups in flight
        step(); lkp_valid_i = 1'b1; lkp_ip_addr_i = $urandom;
        repeat (4) begin step(); lkp_ip_addr_i = $urandom; end
        step(); lkp_valid_i = 1'b0;
        step(); rst = 1'b1; lkp_valid_i = 1'b1;
        @(negedge clk);
        chk("t5_inflight_pre", inflight_o, 5);
        chk("t5_rst_ready", lkp_ready_o, 0);
        step(); rst = 1'b0; lkp_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_inflight", inflight_o, 0);
        chk("t5_stage", stage_id_o, 63);
        chk("t5_ip", ip_addr_o, 0);
        chk("t5_res_valid", res_valid_o, 0);
        r0 = res_cnt;
        repeat (20) step();
        chk("t5_no_res", 64'(res_cnt - r0), 0);

        // back-to-back stream
        r0 = res_cnt; mx = 0;
        step(); lkp_valid_i = 1'b1;
        repeat (40) begin
            lkp_ip_addr_i = $urandom;
            @(negedge clk);
            if (int'(inflight_o) > mx) mx = int'(inflight_o);
            step();
        end
        lkp_valid_i = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (int'(inflight_o) > mx) mx = int'(inflight_o);
            step();
        end
        chk("t6_inflight_max", 64'(mx), 16);
        chk("t6_pulses", 64'(res_cnt - r0), 40);
        chk("sb_empty", 64'(ipq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
